// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame geometry,
// default tuning values and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned FRAME_BITS      = 11;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILTER_LEN  = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 5000;

  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Synchroniser, glitch filter and falling-edge strobe for ps2_clk; ps2_data is
// delayed by the same number of cycles so it lines up with the strobe.
module ps2_edge_filter
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);

  localparam int unsigned DLY = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned CW  = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [DLY-1:0]         r_dat_pipe;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_fall;
  logic                   w_clk_s;
  logic                   w_settle;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_settle = (w_clk_s != r_filt) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_pipe <= '1;
    end else begin
      r_clk_sync[0] <= i_ps2_clk;
      r_dat_pipe[0] <= i_ps2_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_clk_sync[i] <= r_clk_sync[i-1];
      for (int unsigned i = 1; i < DLY; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
    end
  end

  // r_cnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= w_settle && !w_clk_s;
      if (w_clk_s == r_filt) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_filt <= w_clk_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_dat_pipe[DLY-1];

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: frames filtered clock edges into bytes and flags errors.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity via parity_err.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic                 shift_en,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  ps2_state_t           r_state;
  ps2_state_t           w_next;
  logic                 w_fall;
  logic                 w_data;
  logic                 w_tmo_hit;
  logic                 w_stop_eval;
  logic                 w_par_good;
  logic [BW-1:0]        r_bit_cnt;
  logic [TW-1:0]        r_tmo;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_frame_data;
  logic                 r_par;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;

  ps2_edge_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_filter (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_fall    (w_fall),
    .o_data    (w_data)
  );

  assign w_tmo_hit  = rx_en && (r_state != ST_IDLE) && !w_fall && (r_tmo == TMO_LAST);
  assign w_par_good = odd_parity_ok(r_shift, r_par);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!rx_en || w_tmo_hit) begin
      w_next = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_data) w_next = ST_DATA;
        ST_DATA:   if (r_bit_cnt == BIT_LAST) w_next = ST_PARITY;
        ST_PARITY: w_next = ST_STOP;
        ST_STOP:   w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en    = rx_en && w_fall && (r_state == ST_DATA);
    w_stop_eval = rx_en && w_fall && (r_state == ST_STOP);
    busy        = (r_state != ST_IDLE);
  end

  // bit_cnt wraps to 0 on the 8th shift, leaving it cleared for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt    <= '0;
      r_tmo        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_frame_data <= '0;
      r_valid      <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      if (!rx_en || r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_tmo     <= '0;
      end else if (w_fall) begin
        r_tmo <= '0;
      end else if (w_tmo_hit) begin
        r_tmo     <= '0;
        r_bit_cnt <= '0;
        r_ferr    <= 1'b1;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (shift_en) begin
        r_shift   <= {w_data, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if (rx_en && w_fall && r_state == ST_PARITY) r_par <= w_data;
      if (w_stop_eval) begin
        if (!w_data) begin
          r_ferr <= 1'b1;
        end else if (PARITY_EN && !w_par_good) begin
          r_perr <= 1'b1;
        end else begin
          r_valid      <= 1'b1;
          r_frame_data <= r_shift;
        end
      end
    end
  end

  assign frame_data = r_frame_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule
